// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side pop engine.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } rd_state_e;

    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned MAX_READ_LAT = 3;

    // Number of pops still travelling through the FIFO read pipeline.
    function automatic logic [1:0] popcount_lat(input logic [MAX_READ_LAT-1:0] v);
        logic [1:0] n;
        n = '0;
        for (int i = 0; i < MAX_READ_LAT; i++) begin
            n = n + 2'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_pop_reader_if.sv
// FIFO read port plus valid/ready output stream seen by the pop reader.
interface fifo_pop_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             fifo_pop;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data_out;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        output fifo_pop,
        output m_valid,
        output m_data,
        input  fifo_empty,
        input  fifo_data_out,
        input  m_ready
    );

    modport slave (
        input  fifo_pop,
        input  m_valid,
        input  m_data,
        output fifo_empty,
        output fifo_data_out,
        output m_ready
    );

endinterface

// File: rtl/fifo_rd_buf.sv
// Small circular buffer holding captured FIFO words until the stream sink takes them.
module fifo_rd_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    input  logic                   clr,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] occ
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [OccW-1:0]  occ_q;

    // Storage is reset too so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   occ_q <= occ_q + OccW'(1);
                2'b01:   occ_q <= occ_q - OccW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign occ  = occ_q;

    // The pop credit scheme must never let a capture land on a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n)
        (wr_en && !rd_en && !clr) |-> (occ_q != OccW'(DEPTH)));

endmodule

// File: rtl/fifo_pop_reader.sv
// Read-side engine: issues FIFO pops against buffer credit and streams words out in order.
// Optional FIFO_RD_CNT_EN adds a 16-bit rd_count of completed output transfers.
module fifo_pop_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               flush,
    fifo_pop_reader_if.master  bus,
    output logic               busy
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]        rd_count
`endif
);

    localparam int unsigned OccW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SumW = OccW + 1;

    if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_pop_reader: BUF_DEPTH must be a power of 2 and at least 2");
    end
    if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_lat
        $error("fifo_pop_reader: READ_LAT must be within 1..3");
    end

    rd_state_e             state_q, state_d;
    logic [READ_LAT-1:0]   pend_q, pend_d;
    logic [MAX_READ_LAT-1:0] pend_ext;
    logic [1:0]            inflight;
    logic [OccW-1:0]       occ;
    logic [WIDTH-1:0]      head;
    logic                  capture;
    logic                  xfer;
    logic                  pop;
    logic [SumW-1:0]       committed;
    logic [SumW-1:0]       limit;

    assign pend_ext = MAX_READ_LAT'(pend_q);
    assign inflight = popcount_lat(pend_ext);
    assign capture  = pend_q[READ_LAT-1];
    assign xfer     = bus.m_valid && bus.m_ready;

    // A word leaving this cycle frees its slot, so it is credited to the pop
    // decision; without that the pipe could not sustain one pop per cycle.
    assign committed = SumW'(occ) + SumW'(inflight);
    assign limit     = SumW'(BUF_DEPTH) + SumW'(xfer);

    assign pop = (state_q == RUN) && !bus.fifo_empty && !flush && (committed < limit);

    always_comb begin
        pend_d = '0;
        if (!flush) begin
            pend_d[0] = pop;
            for (int i = 1; i < READ_LAT; i++) begin
                pend_d[i] = pend_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (!en) state_d = STOP;
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else if (inflight == '0 && occ == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    fifo_rd_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (capture),
        .wr_data (bus.fifo_data_out),
        .rd_en   (xfer),
        .clr     (flush),
        .head    (head),
        .occ     (occ)
    );

    assign bus.fifo_pop = pop;
    assign bus.m_valid  = (occ != '0);
    assign bus.m_data   = head;
    assign busy         = (occ != '0) || (pend_q != '0);

`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= '0;
        end else if (flush) begin
            rd_count_q <= '0;
        end else if (xfer) begin
            rd_count_q <= rd_count_q + 16'd1;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_pop_reader.sv
// Directed bench for fifo_pop_reader: READ_LAT=1/BUF_DEPTH=2 and READ_LAT=3/BUF_DEPTH=4.
module tb_fifo_pop_reader;
    import fifo_rd_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic en_a, flush_a, busy_a;
    logic en_b, flush_b, busy_b;
`ifdef FIFO_RD_CNT_EN
    logic [15:0] cnt_a, cnt_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_pop_reader_if #(.WIDTH(32)) bus_a ();
    fifo_pop_reader_if #(.WIDTH(32)) bus_b ();

    fifo_pop_reader #(.WIDTH(32), .BUF_DEPTH(2), .READ_LAT(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_a),
        .flush (flush_a),
        .bus   (bus_a),
        .busy  (busy_a)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count (cnt_a)
`endif
    );

    fifo_pop_reader #(.WIDTH(32), .BUF_DEPTH(4), .READ_LAT(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_b),
        .flush (flush_b),
        .bus   (bus_b),
        .busy  (busy_b)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count (cnt_b)
`endif
    );

    // Behavioural FIFOs with fixed read latency; not reset by rst_n.
    logic [31:0] mem_a [64];
    logic [31:0] pipe_a [1];
    int unsigned wr_a = 0, rd_a = 0, pops_a = 0;
    logic [31:0] mem_b [64];
    logic [31:0] pipe_b [3];
    int unsigned wr_b = 0, rd_b = 0, pops_b = 0;

    assign bus_a.fifo_empty    = (rd_a == wr_a);
    assign bus_a.fifo_data_out = pipe_a[0];
    assign bus_b.fifo_empty    = (rd_b == wr_b);
    assign bus_b.fifo_data_out = pipe_b[2];

    always @(posedge clk) begin
        if (bus_a.fifo_pop) begin
            pipe_a[0] <= mem_a[rd_a];
            rd_a      <= rd_a + 1;
            pops_a    <= pops_a + 1;
        end
    end

    always @(posedge clk) begin
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if (bus_b.fifo_pop) begin
            pipe_b[0] <= mem_b[rd_b];
            rd_b      <= rd_b + 1;
            pops_b    <= pops_b + 1;
        end
    end

    logic [31:0] tw [4] = '{32'hDEADBEEF, 32'hCAFEBABE, 32'hFEEDFACE, 32'hBAADF00D};
    logic [31:0] fw [3] = '{32'h11110000, 32'h22220000, 32'h33330000};
    logic [31:0] rw [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    int unsigned base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] w);
        mem_a[wr_a] = w;
        wr_a++;
    endtask

    task automatic push_b(input logic [31:0] w);
        mem_b[wr_b] = w;
        wr_b++;
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b0; flush_a = 1'b0; bus_a.m_ready = 1'b0;
        en_b = 1'b0; flush_b = 1'b0; bus_b.m_ready = 1'b0;
        #3;
        chk("rst_pop",    32'(bus_a.fifo_pop), 32'd0);
        chk("rst_valid",  32'(bus_a.m_valid),  32'd0);
        chk("rst_data",   bus_a.m_data,        32'd0);
        chk("rst_busy",   32'(busy_a),         32'd0);
        chk("rst_state",  32'(dut_a.state_q),  32'(IDLE));
        #20 rst_n = 1'b1;
        tick();

        // Burst drain
        for (int i = 0; i < 4; i++) push_a(tw[i]);
        en_a = 1'b1; bus_a.m_ready = 1'b1;
        tick(); chk("burst_pop1", 32'(bus_a.fifo_pop), 32'd1);
                chk("burst_nv1",  32'(bus_a.m_valid),  32'd0);
        tick(); chk("burst_pop2", 32'(bus_a.fifo_pop), 32'd1);
                chk("burst_nv2",  32'(bus_a.m_valid),  32'd0);
        tick(); chk("burst_d0",   bus_a.m_data,        tw[0]);
                chk("burst_v0",   32'(bus_a.m_valid),  32'd1);
                chk("burst_pop3", 32'(bus_a.fifo_pop), 32'd1);
        tick(); chk("burst_d1",   bus_a.m_data,        tw[1]);
                chk("burst_pop4", 32'(bus_a.fifo_pop), 32'd1);
        tick(); chk("burst_d2",   bus_a.m_data,        tw[2]);
                chk("burst_empty_nopop", 32'(bus_a.fifo_pop), 32'd0);
        tick(); chk("burst_d3",   bus_a.m_data,        tw[3]);
                chk("burst_busy", 32'(busy_a),         32'd1);
        tick(); chk("burst_done_v",    32'(bus_a.m_valid),  32'd0);
                chk("burst_done_busy", 32'(busy_a),         32'd0);
                chk("burst_done_pop",  32'(bus_a.fifo_pop), 32'd0);
                chk("burst_pops",      pops_a,              32'd4);
`ifdef FIFO_RD_CNT_EN
                chk("burst_cnt",       32'(cnt_a),          32'd4);
`endif

        // Backpressure
        bus_a.m_ready = 1'b0;
        base = pops_a;
        for (int i = 0; i < 4; i++) push_a(tw[i]);
        repeat (10) tick();
        chk("bp_pops2",  pops_a - base,      32'd2);
        chk("bp_valid",  32'(bus_a.m_valid), 32'd1);
        chk("bp_hold",   bus_a.m_data,       tw[0]);
        bus_a.m_ready = 1'b1;
        tick(); chk("bp_d1", bus_a.m_data, tw[1]);
        tick(); chk("bp_d2", bus_a.m_data, tw[2]);
        tick(); chk("bp_d3", bus_a.m_data, tw[3]);
        tick(); chk("bp_done_v", 32'(bus_a.m_valid), 32'd0);
                chk("bp_pops4",  pops_a - base,      32'd4);

        // Stop mid-burst
        base = pops_a;
        for (int i = 0; i < 4; i++) push_a(tw[i]);
        tick();
        en_a = 1'b0;
        tick(); chk("stop_d0",    bus_a.m_data,        tw[0]);
                chk("stop_nopop", 32'(bus_a.fifo_pop), 32'd0);
        tick(); chk("stop_d1",    bus_a.m_data,        tw[1]);
        tick(); chk("stop_v",     32'(bus_a.m_valid),  32'd0);
                chk("stop_busy",  32'(busy_a),         32'd0);
        tick(); chk("stop_idle",  32'(dut_a.state_q),  32'(IDLE));
                chk("stop_pops",  pops_a - base,       32'd2);
                chk("stop_left",  wr_a - rd_a,         32'd2);
        en_a = 1'b1;
        tick(); tick();
        tick(); chk("stop_d2", bus_a.m_data, tw[2]);
        tick(); chk("stop_d3", bus_a.m_data, tw[3]);
        tick(); chk("stop_done_v", 32'(bus_a.m_valid), 32'd0);

        // Flush with an in-flight word
        for (int i = 0; i < 3; i++) push_a(fw[i]);
        tick();
        flush_a = 1'b1;
        #1 chk("flush_nopop", 32'(bus_a.fifo_pop), 32'd0);
        tick();
        flush_a = 1'b0;
        chk("flush_v", 32'(bus_a.m_valid), 32'd0);
        tick();
        tick(); chk("flush_d1", bus_a.m_data, fw[1]);
        tick(); chk("flush_d2", bus_a.m_data, fw[2]);
        tick(); chk("flush_done_v", 32'(bus_a.m_valid), 32'd0);
`ifdef FIFO_RD_CNT_EN
                chk("flush_cnt", 32'(cnt_a), 32'd2);
`endif

        // Asynchronous reset mid-burst
        for (int i = 0; i < 4; i++) push_a(rw[i]);
        tick();
        tick(); chk("ar_pre_v",   32'(bus_a.m_valid),  32'd1);
                chk("ar_pre_pop", 32'(bus_a.fifo_pop), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("ar_pop",  32'(bus_a.fifo_pop), 32'd0);
           chk("ar_v",    32'(bus_a.m_valid),  32'd0);
           chk("ar_busy", 32'(busy_a),         32'd0);
           chk("ar_data", bus_a.m_data,        32'd0);
        #2 rst_n = 1'b1;
        tick(); tick();
        tick(); chk("ar_d2", bus_a.m_data, rw[2]);
        tick(); chk("ar_d3", bus_a.m_data, rw[3]);
        tick(); chk("ar_done_v", 32'(bus_a.m_valid), 32'd0);

        // Latency sweep: READ_LAT=3, BUF_DEPTH=4
        for (int i = 0; i < 4; i++) push_b(tw[i]);
        en_b = 1'b1; bus_b.m_ready = 1'b1;
        tick(); chk("lat_pop1", 32'(bus_b.fifo_pop), 32'd1);
        tick(); chk("lat_pop2", 32'(bus_b.fifo_pop), 32'd1);
        tick(); chk("lat_pop3", 32'(bus_b.fifo_pop), 32'd1);
                chk("lat_nv3",  32'(bus_b.m_valid),  32'd0);
        tick(); chk("lat_pop4", 32'(bus_b.fifo_pop), 32'd1);
                chk("lat_nv4",  32'(bus_b.m_valid),  32'd0);
        tick(); chk("lat_v0",   32'(bus_b.m_valid),  32'd1);
                chk("lat_d0",   bus_b.m_data,        tw[0]);
                chk("lat_nopop", 32'(bus_b.fifo_pop), 32'd0);
        tick(); chk("lat_d1",   bus_b.m_data,        tw[1]);
        tick(); chk("lat_d2",   bus_b.m_data,        tw[2]);
        tick(); chk("lat_d3",   bus_b.m_data,        tw[3]);
        tick(); chk("lat_done_v",    32'(bus_b.m_valid), 32'd0);
                chk("lat_done_busy", 32'(busy_b),        32'd0);
                chk("lat_pops",      pops_b,             32'd4);
`ifdef FIFO_RD_CNT_EN
                chk("lat_cnt",       32'(cnt_b),         32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
